// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between one master and the SRAM slave.
// The interconnect drives hready; in a single-slave system it is the slave's own hreadyout.
interface ahb_lite_sram_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  hsel;
   logic [ADDR_WIDTH-1:0] haddr;
   logic [1:0]            htrans;
   logic                  hwrite;
   logic [2:0]            hsize;
   logic [3:0]            hprot;
   logic [DATA_WIDTH-1:0] hwdata;
   logic                  hready;
   logic                  hreadyout;
   logic                  hresp;
   logic [DATA_WIDTH-1:0] hrdata;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata,
      input  hready, hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: flop word memory, byte-lane writes, fixed wait states, two-cycle ERROR.
// Optional feature: define AHB_SRAM_PRIV_WRITE_EN to reject user-mode (hprot[1]=0) writes.
module ahb_lite_sram_slave #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input logic                  hclk,
   input logic                  hreset_n,
   ahb_lite_sram_slave_if.slave bus
);

   localparam int NBYTES     = DATA_WIDTH / 8;
   localparam int LOG2_BYTES = $clog2(NBYTES);
   localparam int OFF_W      = (LOG2_BYTES > 0) ? LOG2_BYTES : 1;
   localparam int IDX_FULL_W = ADDR_WIDTH - LOG2_BYTES;
   localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t              state;
   logic [3:0]          cnt;
   logic                write_q;
   logic [IDX_W-1:0]    word_q;
   logic [NBYTES-1:0]   be_q;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  accept;
   logic                  can_start;
   logic                  take;
   logic                  wr_fire;
   logic                  size_err;
   logic                  align_err;
   logic                  range_err;
   logic                  priv_err;
   logic                  acc_err;
   logic [7:0]            size_mask;
   logic [IDX_FULL_W-1:0] acc_full_idx;
   logic [IDX_W-1:0]      acc_idx;
   logic [OFF_W-1:0]      acc_off;
   logic [NBYTES-1:0]     acc_be;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  unused_ok;

   function automatic logic [NBYTES-1:0] lane_mask(input logic [OFF_W-1:0] off,
                                                   input logic [2:0]       size);
      logic [NBYTES-1:0] m;
      int lo;
      int hi;
      lo = int'(off);
      hi = lo + (1 << size);
      for (int i = 0; i < NBYTES; i++) begin
         m[i] = (i >= lo) && (i < hi);
      end
      return m;
   endfunction

   assign unused_ok = ^{bus.htrans[0], bus.hprot};

   // Address-phase decode, error classification and the read path with write forwarding.
   always_comb begin
      accept       = bus.hsel & bus.hready & bus.htrans[1];
      can_start    = (state == S_IDLE) || (state == S_ERR2) ||
                     ((state == S_DATA) && (cnt == 4'd0));
      take         = accept & can_start;
      wr_fire      = (state == S_DATA) && (cnt == 4'd0) && write_q;

      acc_full_idx = bus.haddr[ADDR_WIDTH-1:LOG2_BYTES];
      acc_idx      = acc_full_idx[IDX_W-1:0];
      acc_off      = bus.haddr[OFF_W-1:0] & OFF_W'(NBYTES - 1);
      size_mask    = 8'((9'd1 << bus.hsize) - 9'd1);

      size_err     = bus.hsize > 3'(LOG2_BYTES);
      align_err    = |(bus.haddr[7:0] & size_mask);
      range_err    = acc_full_idx >= IDX_FULL_W'(MEM_DEPTH);
`ifdef AHB_SRAM_PRIV_WRITE_EN
      priv_err     = bus.hwrite & ~bus.hprot[1];
`else
      priv_err     = 1'b0;
`endif
      acc_err      = size_err | align_err | range_err | priv_err;
      acc_be       = lane_mask(acc_off, bus.hsize);

      // A write retiring this cycle has not reached mem yet, so merge its lanes in.
      rd_word = mem[acc_idx];
      if (wr_fire && (word_q == acc_idx)) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (be_q[i]) begin
               rd_word[8*i +: 8] = bus.hwdata[8*i +: 8];
            end
         end
      end
   end

   // Transfer sequencing with registered hreadyout/hresp/hrdata.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state         <= S_IDLE;
         cnt           <= 4'd0;
         write_q       <= 1'b0;
         word_q        <= '0;
         be_q          <= '0;
         bus.hreadyout <= 1'b1;
         bus.hresp     <= 1'b0;
         bus.hrdata    <= '0;
      end else begin
         if (state == S_ERR1) begin
            state         <= S_ERR2;
            bus.hreadyout <= 1'b1;
            bus.hresp     <= 1'b1;
         end else if ((state == S_DATA) && (cnt != 4'd0)) begin
            cnt           <= cnt - 4'd1;
            bus.hreadyout <= (cnt == 4'd1);
            bus.hresp     <= 1'b0;
         end else if (take) begin
            write_q <= bus.hwrite;
            word_q  <= acc_idx;
            be_q    <= acc_be;
            if (acc_err) begin
               state         <= S_ERR1;
               write_q       <= 1'b0;
               bus.hreadyout <= 1'b0;
               bus.hresp     <= 1'b1;
               if (!bus.hwrite) begin
                  bus.hrdata <= '0;
               end
            end else begin
               state         <= S_DATA;
               cnt           <= 4'(WAIT_STATES);
               bus.hreadyout <= (WAIT_STATES == 0);
               bus.hresp     <= 1'b0;
               if (!bus.hwrite) begin
                  bus.hrdata <= rd_word;
               end
            end
         end else begin
            state         <= S_IDLE;
            write_q       <= 1'b0;
            bus.hreadyout <= 1'b1;
            bus.hresp     <= 1'b0;
         end
      end
   end

   // Memory is deliberately not reset; wr_fire is already low while hreset_n is asserted.
   always_ff @(posedge hclk) begin
      if (wr_fire) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (be_q[i]) begin
               mem[word_q][8*i +: 8] <= bus.hwdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Scoreboard bench for ahb_lite_sram_slave: one instance with no wait states, one with three.
// Both share the master-side signals; dut_sel chooses which instance is selected and observed.
module tb_ahb_lite_sram_slave;

   localparam int AW       = 32;
   localparam int DW       = 32;
   localparam int DEPTH    = 1024;
   localparam int BUDGET   = 400;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] data;
      logic [3:0]  prot;
   } op_t;

   typedef struct {
      logic        err;
      logic        rd;
      logic [31:0] data;
      int          low;
   } exp_t;

   logic        hclk = 1'b0;
   logic        hreset_n = 1'b0;
   int          dut_sel = 0;
   logic        hsel = 1'b0;
   logic [31:0] haddr = '0;
   logic [1:0]  htrans = 2'b00;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'd2;
   logic [3:0]  hprot = 4'b0011;
   logic [31:0] hwdata = '0;

   int vectors = 0;
   int miscompares = 0;

   op_t         ops[$];
   exp_t        sb[$];
   logic [31:0] model_mem [2][DEPTH];

   ahb_lite_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
   ahb_lite_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

   assign bus0.hsel   = hsel & (dut_sel == 0);
   assign bus0.haddr  = haddr;
   assign bus0.htrans = htrans;
   assign bus0.hwrite = hwrite;
   assign bus0.hsize  = hsize;
   assign bus0.hprot  = hprot;
   assign bus0.hwdata = hwdata;
   assign bus0.hready = bus0.hreadyout;

   assign bus1.hsel   = hsel & (dut_sel == 1);
   assign bus1.haddr  = haddr;
   assign bus1.htrans = htrans;
   assign bus1.hwrite = hwrite;
   assign bus1.hsize  = hsize;
   assign bus1.hprot  = hprot;
   assign bus1.hwdata = hwdata;
   assign bus1.hready = bus1.hreadyout;

   ahb_lite_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
      .hclk     (hclk),
      .hreset_n (hreset_n),
      .bus      (bus0)
   );

   ahb_lite_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
      .hclk     (hclk),
      .hreset_n (hreset_n),
      .bus      (bus1)
   );

   always #5 hclk = ~hclk;

   // One comparison; every check in the bench funnels through here.
   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   // Reference model: decides the response and updates the model memory at acceptance.
   function automatic exp_t predict(input int d, input op_t op);
      exp_t e;
      int   off;
      int   idx;
      logic err;
      off = int'(op.addr[1:0]);
      idx = int'(op.addr >> 2);
      err = (op.size > 3'd2) || ((op.addr & ((32'd1 << op.size) - 32'd1)) != 32'd0) || (idx >= DEPTH);
`ifdef AHB_SRAM_PRIV_WRITE_EN
      err = err || (op.wr && !op.prot[1]);
`endif
      e.err  = err;
      e.rd   = !op.wr;
      e.low  = err ? 1 : ws_of(d);
      e.data = 32'd0;
      if (!err && op.wr) begin
         for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + (1 << op.size)) begin
               model_mem[d][idx][8*b +: 8] = op.data[8*b +: 8];
            end
         end
      end
      if (!err && !op.wr) begin
         e.data = model_mem[d][idx];
      end
      return e;
   endfunction

   task automatic push_op(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                          input logic [31:0] data, input logic [3:0] prot);
      op_t op;
      op.addr = addr;
      op.wr   = wr;
      op.size = size;
      op.data = data;
      op.prot = prot;
      ops.push_back(op);
   endtask

   task automatic drive_addr();
      if (ops.size() > 0) begin
         hsel   = 1'b1;
         htrans = 2'b10;
         haddr  = ops[0].addr;
         hwrite = ops[0].wr;
         hsize  = ops[0].size;
         hprot  = ops[0].prot;
      end else begin
         hsel   = 1'b0;
         htrans = 2'b00;
      end
   endtask

   // Pipelined master: pushes expectations on acceptance, pops them when each data phase ends.
   task automatic apply_stimulus(input int d);
      exp_t        cur;
      op_t         op;
      int          low = 0;
      int          cycles = 0;
      bit          acc;
      logic        r;
      logic        resp;
      logic [31:0] rdata;
      dut_sel = d;
      drive_addr();
      while ((ops.size() > 0 || sb.size() > 0) && cycles < BUDGET) begin
         cycles++;
         @(negedge hclk);
         r     = (d == 0) ? bus0.hreadyout : bus1.hreadyout;
         resp  = (d == 0) ? bus0.hresp     : bus1.hresp;
         rdata = (d == 0) ? bus0.hrdata    : bus1.hrdata;
         if (sb.size() > 0) begin
            if (!r) begin
               low++;
               check_output("resp_while_waiting", {31'd0, resp}, {31'd0, sb[0].err});
            end else begin
               cur = sb.pop_front();
               check_output("low_cycles", low, cur.low);
               check_output("resp_final", {31'd0, resp}, {31'd0, cur.err});
               if (cur.rd) begin
                  check_output("hrdata", rdata, cur.data);
               end
            end
         end
         acc = r && (ops.size() > 0);
         if (acc) begin
            op = ops.pop_front();
            sb.push_back(predict(d, op));
            low = 0;
         end
         @(posedge hclk);
         #1;
         if (acc) begin
            hwdata = op.data;
         end
         drive_addr();
      end
      if (cycles >= BUDGET) begin
         check_output("timeout", 32'd1, 32'd0);
         ops.delete();
         sb.delete();
      end
   endtask

   initial begin
      $display("[TB] start");
      repeat (2) @(posedge hclk);
      #1;
      check_output("rst_hreadyout0", {31'd0, bus0.hreadyout}, 32'd1);
      check_output("rst_hresp0",     {31'd0, bus0.hresp},     32'd0);
      check_output("rst_hrdata0",    bus0.hrdata,             32'd0);
      check_output("rst_hreadyout1", {31'd0, bus1.hreadyout}, 32'd1);
      check_output("rst_hresp1",     {31'd0, bus1.hresp},     32'd0);
      check_output("rst_hrdata1",    bus1.hrdata,             32'd0);
      @(negedge hclk);
      hreset_n = 1'b1;
      @(posedge hclk);
      #1;

      // Word write then immediate read of the same word, and byte-lane merge with forwarding.
      push_op(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 4'b0011);
      push_op(32'h10, 1'b0, 3'd2, 32'h0,        4'b0011);
      push_op(32'h10, 1'b1, 3'd2, 32'h11223344, 4'b0011);
      push_op(32'h13, 1'b1, 3'd0, 32'hAA000000, 4'b0011);
      push_op(32'h10, 1'b0, 3'd2, 32'h0,        4'b0011);
      push_op(32'h11, 1'b1, 3'd1, 32'h0000BEEF, 4'b0011);
      push_op(32'h12, 1'b0, 3'd1, 32'h0,        4'b0011);
      push_op(32'h10, 1'b0, 3'd2, 32'h0,        4'b0011);
      // Out-of-range and oversize accesses must not disturb memory.
      push_op(32'h0,    1'b1, 3'd2, 32'hCAFEF00D, 4'b0011);
      push_op(32'h1000, 1'b0, 3'd2, 32'h0,        4'b0011);
      push_op(32'h1000, 1'b1, 3'd2, 32'h12345678, 4'b0011);
      push_op(32'h8,    1'b1, 3'd3, 32'h87654321, 4'b0011);
      push_op(32'h0,    1'b0, 3'd2, 32'h0,        4'b0011);
      push_op(32'h0,    1'b0, 3'd2, 32'h0,        4'b0011);
      // Privileged versus user writes.
      push_op(32'h20, 1'b1, 3'd2, 32'h00000055, 4'b0011);
      push_op(32'h20, 1'b1, 3'd2, 32'h00000066, 4'b0001);
      push_op(32'h20, 1'b0, 3'd2, 32'h0,        4'b0001);
      apply_stimulus(0);

      // Wait-state instance: back-to-back writes, then reads.
      push_op(32'h0, 1'b1, 3'd2, 32'h01020304, 4'b0011);
      push_op(32'h4, 1'b1, 3'd2, 32'hA0B0C0D0, 4'b0011);
      push_op(32'h0, 1'b0, 3'd2, 32'h0,        4'b0011);
      push_op(32'h4, 1'b0, 3'd2, 32'h0,        4'b0011);
      push_op(32'h8, 1'b1, 3'd2, 32'h5A5A5A5A, 4'b0011);
      push_op(32'h8, 1'b0, 3'd2, 32'h0,        4'b0011);
      push_op(32'h6, 1'b0, 3'd2, 32'h0,        4'b0011);
      push_op(32'h4, 1'b0, 3'd2, 32'h0,        4'b0011);
      apply_stimulus(1);

      // Reset lands inside a write's wait states; the write must be lost.
      dut_sel = 1;
      hsel    = 1'b1;
      htrans  = 2'b10;
      haddr   = 32'h4;
      hwrite  = 1'b1;
      hsize   = 3'd2;
      hprot   = 4'b0011;
      @(posedge hclk);
      #1;
      hsel    = 1'b0;
      htrans  = 2'b00;
      hwdata  = 32'hFFFF0000;
      @(posedge hclk);
      #1;
      check_output("t5_in_wait",    {31'd0, bus1.hreadyout}, 32'd0);
      check_output("t5_hrdata_pre", bus1.hrdata,             32'hA0B0C0D0);
      hreset_n = 1'b0;
      #1;
      check_output("t5_hreadyout", {31'd0, bus1.hreadyout}, 32'd1);
      check_output("t5_hresp",     {31'd0, bus1.hresp},     32'd0);
      check_output("t5_hrdata",    bus1.hrdata,             32'd0);
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      hreset_n = 1'b1;
      @(posedge hclk);
      #1;
      push_op(32'h4, 1'b0, 3'd2, 32'h0, 4'b0011);
      push_op(32'h0, 1'b0, 3'd2, 32'h0, 4'b0011);
      apply_stimulus(1);

      // Memory of the other instance survives the reset as well.
      push_op(32'h10, 1'b0, 3'd2, 32'h0, 4'b0011);
      apply_stimulus(0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
